// File: rtl/rc_osc_freq_monitor.sv
// Gated edge counter that checks an RC oscillator's frequency against a lo/hi window.
// The result appears with the count_valid pulse, SETTLE_CYCLES+GATE_CYCLES cycles after start is accepted.
module rc_osc_freq_monitor #(
   parameter int unsigned SETTLE_CYCLES = 1000,
   parameter int unsigned GATE_CYCLES   = 10000,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             continuous,
   input  logic             osc_in,
   input  logic [CNT_W-1:0] lo_thresh,
   input  logic [CNT_W-1:0] hi_thresh,
   output logic             osc_ena,
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic             count_valid,
   output logic             too_slow,
   output logic             too_fast,
   output logic             stuck
);

   localparam int unsigned TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               too_slow_q, too_slow_d;
   logic               too_fast_q, too_fast_d;
   logic               stuck_q, stuck_d;
   logic               sync1_q, sync1_d;
   logic               sync2_q, sync2_d;
   logic               dly_q, dly_d;
   logic [1:0]         real_q, real_d;
   logic               armed_q, armed_d;
   logic               osc_edge;
   logic [CNT_W-1:0]   cnt_inc;

   // real_q marks sync2 as holding a post-reset sample; armed_q means a genuine low has been seen,
   // so a level that is already high when reset releases is never taken as an edge.
   assign osc_edge = armed_q & sync2_q & ~dly_q;
   assign cnt_inc  = (osc_edge && (edge_cnt_q != '1)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      edge_cnt_d = edge_cnt_q;
      count_d    = count_q;
      too_slow_d = too_slow_q;
      too_fast_d = too_fast_q;
      stuck_d    = stuck_q;
      sync1_d    = osc_in;
      sync2_d    = sync1_q;
      dly_d      = sync2_q;
      real_d     = {real_q[0], 1'b1};
      armed_d    = armed_q | (real_q[1] & ~sync2_q);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SETTLE;
               timer_d = TMR_W'(SETTLE_CYCLES - 1);
            end
         end
         ST_SETTLE: begin
            if (timer_q == '0) begin
               state_d    = ST_MEASURE;
               timer_d    = TMR_W'(GATE_CYCLES - 1);
               edge_cnt_d = '0;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_MEASURE: begin
            edge_cnt_d = cnt_inc;
            // Result registers load on the last gate cycle so they are valid alongside count_valid.
            if (timer_q == '0) begin
               state_d    = ST_DONE;
               count_d    = cnt_inc;
               too_slow_d = cnt_inc < lo_thresh;
               too_fast_d = cnt_inc > hi_thresh;
               stuck_d    = cnt_inc == '0;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_DONE: begin
            if (continuous) begin
               state_d    = ST_MEASURE;
               timer_d    = TMR_W'(GATE_CYCLES - 1);
               edge_cnt_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         edge_cnt_q <= '0;
         count_q    <= '0;
         too_slow_q <= 1'b0;
         too_fast_q <= 1'b0;
         stuck_q    <= 1'b0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         dly_q      <= 1'b0;
         real_q     <= '0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         edge_cnt_q <= edge_cnt_d;
         count_q    <= count_d;
         too_slow_q <= too_slow_d;
         too_fast_q <= too_fast_d;
         stuck_q    <= stuck_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         dly_q      <= dly_d;
         real_q     <= real_d;
         armed_q    <= armed_d;
      end
   end

   assign osc_ena     = (state_q != ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign count_valid = (state_q == ST_DONE);
   assign count       = count_q;
   assign too_slow    = too_slow_q;
   assign too_fast    = too_fast_q;
   assign stuck       = stuck_q;

endmodule

// File: tb/tb_rc_osc_freq_monitor.sv
// Randomized bench for rc_osc_freq_monitor: a cycle-indexed sample history and a window schedule predict every output.
module tb_rc_osc_freq_monitor;

   localparam int S    = 20;
   localparam int G    = 200;
   localparam int W    = 8;
   localparam int WS   = 4;
   localparam int MAXC = 100000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          continuous = 1'b0;
   logic          osc_in = 1'b0;
   logic [W-1:0]  lo = '0;
   logic [W-1:0]  hi = '0;

   logic          osc_ena, busy, count_valid, too_slow, too_fast, stuck;
   logic [W-1:0]  count;
   logic          s_osc_ena, s_busy, s_count_valid, s_too_slow, s_too_fast, s_stuck;
   logic [WS-1:0] s_count;

   rc_osc_freq_monitor #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(W)) u_dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .osc_in(osc_in),
      .lo_thresh(lo), .hi_thresh(hi), .osc_ena(osc_ena), .busy(busy), .count(count),
      .count_valid(count_valid), .too_slow(too_slow), .too_fast(too_fast), .stuck(stuck)
   );

   rc_osc_freq_monitor #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(WS)) u_sat (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .osc_in(osc_in),
      .lo_thresh(lo[WS-1:0]), .hi_thresh(hi[WS-1:0]), .osc_ena(s_osc_ena), .busy(s_busy),
      .count(s_count), .count_valid(s_count_valid), .too_slow(s_too_slow),
      .too_fast(s_too_fast), .stuck(s_stuck)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      else
         n_pass++;
   endtask

   // Reference model: history of osc_in samples per clock edge plus the window schedule.
   bit osc_h [MAXC];
   bit real_h[MAXC];
   bit m_busy = 0;
   bit m_vld = 0;
   int ws = 0;
   int done_e = -1;
   int m_cnt = 0, m_cnt_s = 0;
   bit m_slow = 0, m_fast = 0, m_stuck = 0;
   bit ms_slow = 0, ms_fast = 0, ms_stuck = 0;

   always @(posedge clk) begin
      int n;
      if (cyc < MAXC) begin
         osc_h[cyc]  = osc_in;
         real_h[cyc] = !rst;
      end
      if (rst) begin
         m_busy = 0;
         m_cnt = 0; m_cnt_s = 0;
         m_slow = 0; m_fast = 0; m_stuck = 0;
         ms_slow = 0; ms_fast = 0; ms_stuck = 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1;
            ws = cyc + S;
            done_e = ws + G;
         end
      end else if (cyc == done_e + 1) begin
         if (continuous) begin
            ws = cyc;
            done_e = ws + G;
         end else begin
            m_busy = 0;
         end
      end
      m_vld = !rst && m_busy && (cyc == done_e);
      if (m_vld) begin
         // A rising edge is a real 0 sample followed by a real 1 sample; it is counted in the
         // cycle where it has travelled through the synchronizer.
         n = 0;
         for (int k = ws; k < done_e; k++)
            if (k >= 2 && real_h[k-1] && real_h[k-2] && !osc_h[k-2] && osc_h[k-1]) n++;
         m_cnt   = (n > (1 << W) - 1)  ? (1 << W) - 1  : n;
         m_cnt_s = (n > (1 << WS) - 1) ? (1 << WS) - 1 : n;
         m_slow  = m_cnt < int'(lo);
         m_fast  = m_cnt > int'(hi);
         m_stuck = (m_cnt == 0);
         ms_slow  = m_cnt_s < int'(lo[WS-1:0]);
         ms_fast  = m_cnt_s > int'(hi[WS-1:0]);
         ms_stuck = (m_cnt_s == 0);
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("busy",      busy,          m_busy);
         chk("osc_ena",   osc_ena,       m_busy);
         chk("cnt_vld",   count_valid,   m_vld);
         chk("count",     count,         m_cnt);
         chk("too_slow",  too_slow,      m_slow);
         chk("too_fast",  too_fast,      m_fast);
         chk("stuck",     stuck,         m_stuck);
         chk("s_busy",    s_busy,        m_busy);
         chk("s_cnt_vld", s_count_valid, m_vld);
         chk("s_count",   s_count,       m_cnt_s);
         chk("s_slow",    s_too_slow,    ms_slow);
         chk("s_fast",    s_too_fast,    ms_fast);
         chk("s_stuck",   s_stuck,       ms_stuck);
         chk("s_osc_ena", s_osc_ena,     m_busy);
      end
   end

   // Oscillator source: 0 = static level, 1 = square wave of osc_half cycles per phase, 2 = random.
   int osc_mode = 0;
   int osc_half = 5;
   bit osc_lvl = 0;
   int ph = 0;

   always @(posedge clk) begin
      #3;
      case (osc_mode)
         0: osc_in = osc_lvl;
         1: begin
            ph++;
            if (ph >= osc_half) begin
               ph = 0;
               osc_in = ~osc_in;
            end
         end
         default: osc_in = 1'($urandom % 2);
      endcase
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   // One measurement: pulse start, keep poking start while busy, optional continuous windows
   // (dropped mid-window after npulse results) and optional reset abort at cycle abort_at.
   task automatic run_one(input bit cont_en, input int npulse, input int abort_at);
      int t;
      int pulses;
      t = 0;
      pulses = 0;
      continuous = cont_en;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      while (busy && t < 5000) begin
         if (count_valid) pulses++;
         if (cont_en && pulses >= npulse && !count_valid) continuous = 1'b0;
         start = ($urandom % 4 == 0);
         rst = (abort_at > 0 && t == abort_at);
         tick(1);
         t++;
      end
      start = 1'b0;
      rst = 1'b0;
      continuous = 1'b0;
      chk("no_timeout", (t < 5000), 1);
      tick($urandom % 5);
   endtask

   initial begin
      tick(3);
      rst = 1'b0;
      tick(2);

      osc_mode = 1; osc_half = 5; lo = 18; hi = 22;     // nominal, 20 edges
      run_one(0, 0, 0);
      osc_mode = 0; osc_lvl = 0;                         // stuck low
      run_one(0, 0, 0);
      osc_lvl = 1;                                       // stuck high, held through reset
      rst = 1'b1; tick(2); rst = 1'b0;
      run_one(0, 0, 0);
      osc_mode = 1; osc_half = 1; hi = 22;               // fast, 100 edges
      run_one(0, 0, 0);
      osc_half = 20;                                     // slow, 5 edges
      run_one(0, 0, 0);
      osc_half = 4;                                      // continuous windows
      run_one(1, 3, 0);
      run_one(0, 0, S + 50);                             // abort mid-measure
      run_one(0, 0, 5);                                  // abort mid-settle
      run_one(1, 2, S + G + 40);                         // abort in a second continuous window

      for (int i = 0; i < 20; i++) begin
         int a, b, ab;
         osc_mode = $urandom % 3;
         osc_lvl  = 1'($urandom % 2);
         osc_half = 1 + $urandom % 12;
         a = $urandom % 256;
         b = $urandom % 256;
         lo = W'((a < b) ? a : b);
         hi = W'((a < b) ? b : a);
         ab = ($urandom % 5 == 0) ? 1 + $urandom % (S + G) : 0;
         run_one(1'($urandom % 2), 1 + $urandom % 2, ab);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
